// File: rtl/xy_mult_pkg.sv
// Shared constants for the iterative multiplier peripheral: register map,
// control/status bit positions and the core sequencer states.
package xy_mult_pkg;

   localparam logic [2:0] A_X   = 3'd0;
   localparam logic [2:0] A_Y   = 3'd1;
   localparam logic [2:0] A_PLO = 3'd2;
   localparam logic [2:0] A_PHI = 3'd3;
   localparam logic [2:0] A_CSR = 3'd4;

   // Write-side control bits
   localparam int CSR_START  = 0;
   localparam int CSR_SIGNED = 1;
   // Read-side status bits
   localparam int CSR_BUSY   = 0;
   localparam int CSR_DONE   = 1;
   localparam int CSR_ERR    = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_e;

endpackage

// File: rtl/xy_seq_multiplier_if.sv
// Register-bus bundle between the processor side (master) and the
// multiplier peripheral (slave).
interface xy_seq_multiplier_if #(
   parameter int WIDTH = 16
);
   logic             e;
   logic             w;
   logic             r;
   logic [2:0]       addr;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] dout;
   logic             done;

   modport master (output e, w, r, addr, d, input dout, done);
   modport slave  (input e, w, r, addr, d, output dout, done);
endinterface

// File: rtl/xy_mult_core.sv
// Radix-2 shift-add multiply engine: magnitude conversion on start, one
// multiplier bit per cycle, then a sign-fix cycle that writes the product.
module xy_mult_core
   import xy_mult_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic               signed_i,
   input  logic [WIDTH-1:0]   x_i,
   input  logic [WIDTH-1:0]   y_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [2*WIDTH-1:0] product_o
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e               state_q;
   logic [WIDTH-1:0]     mcand_q;
   logic [WIDTH-1:0]     mplier_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [2*WIDTH-1:0]   product_q;
   logic [CW-1:0]        cnt_q;
   logic                 sign_q;
   logic                 busy_q;

   logic [WIDTH-1:0]     x_mag_s;
   logic [WIDTH-1:0]     y_mag_s;
   logic [2*WIDTH-1:0]   addend_s;

   // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned
   always_comb begin
      x_mag_s  = (signed_i && x_i[WIDTH-1]) ? (~x_i + WIDTH'(1'b1)) : x_i;
      y_mag_s  = (signed_i && y_i[WIDTH-1]) ? (~y_i + WIDTH'(1'b1)) : y_i;
      addend_s = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
   end

   // Sequencer: IDLE -> RUN (WIDTH cycles) -> FIX -> IDLE
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         mcand_q   <= {WIDTH{1'b0}};
         mplier_q  <= {WIDTH{1'b0}};
         acc_q     <= {(2*WIDTH){1'b0}};
         product_q <= {(2*WIDTH){1'b0}};
         cnt_q     <= {CW{1'b0}};
         sign_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  mcand_q  <= x_mag_s;
                  mplier_q <= y_mag_s;
                  sign_q   <= signed_i & (x_i[WIDTH-1] ^ y_i[WIDTH-1]);
                  acc_q    <= {(2*WIDTH){1'b0}};
                  cnt_q    <= {CW{1'b0}};
                  busy_q   <= 1'b1;
                  state_q  <= RUN;
               end
            end
            RUN: begin
               if (mplier_q[0]) begin
                  acc_q <= acc_q + addend_s;
               end
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               product_q <= sign_q ? (~acc_q + (2*WIDTH)'(1'b1)) : acc_q;
               busy_q    <= 1'b0;
               state_q   <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy_o    = busy_q;
   assign done_o    = (state_q == FIX);
   assign product_o = product_q;
endmodule

// File: rtl/xy_seq_multiplier.sv
// Memory-mapped multiplier peripheral: bus decode, operand and status
// registers, registered read port, and the shift-add core.
module xy_seq_multiplier
   import xy_mult_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter bit SIGNED_EN = 1'b1
) (
   input logic                 clk_i,
   input logic                 rst_ni,
   xy_seq_multiplier_if.slave  bus
);
   logic [WIDTH-1:0]   x_q, x_d;
   logic [WIDTH-1:0]   y_q, y_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               rd_s, wr_s, start_s, signed_s, busy_s, fix_s;
   logic [WIDTH-1:0]   status_s;
   logic [2*WIDTH-1:0] product_s;

   xy_mult_core #(.WIDTH(WIDTH)) u_core (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .start_i   (start_s),
      .signed_i  (signed_s),
      .x_i       (x_q),
      .y_i       (y_q),
      .busy_o    (busy_s),
      .done_o    (fix_s),
      .product_o (product_s)
   );

   // Bus decode; DONE set by the fix cycle takes priority over read-to-clear
   always_comb begin
      x_d      = x_q;
      y_d      = y_q;
      out_d    = out_q;
      done_d   = done_q;
      err_d    = err_q;
      start_s  = 1'b0;
      rd_s     = bus.e & bus.r;
      wr_s     = bus.e & bus.w;
      signed_s = bus.d[CSR_SIGNED] & SIGNED_EN;
      status_s = {WIDTH{1'b0}};
      status_s[CSR_BUSY] = busy_s;
      status_s[CSR_DONE] = done_q;
      status_s[CSR_ERR]  = err_q;

      if (rd_s) begin
         case (bus.addr)
            A_X:     out_d = x_q;
            A_Y:     out_d = y_q;
            A_PLO:   out_d = product_s[WIDTH-1:0];
            A_PHI:   out_d = product_s[2*WIDTH-1:WIDTH];
            A_CSR: begin
               out_d  = status_s;
               done_d = 1'b0;
               err_d  = 1'b0;
            end
            default: out_d = {WIDTH{1'b0}};
         endcase
      end else begin
         out_d = out_q;
      end

      if (wr_s) begin
         case (bus.addr)
            A_X: begin
               if (busy_s) err_d = 1'b1;
               else        x_d   = bus.d;
            end
            A_Y: begin
               if (busy_s) err_d = 1'b1;
               else        y_d   = bus.d;
            end
            A_CSR: begin
               if (busy_s) begin
                  err_d = 1'b1;
               end else if (bus.d[CSR_START]) begin
                  start_s = 1'b1;
                  done_d  = 1'b0;
               end else begin
                  start_s = 1'b0;
               end
            end
            default: start_s = 1'b0;
         endcase
      end else begin
         start_s = 1'b0;
      end

      if (fix_s) begin
         done_d = 1'b1;
      end else begin
         done_d = done_d;
      end
   end

   // Register state; reset overrides any concurrent bus activity
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         x_q    <= {WIDTH{1'b0}};
         y_q    <= {WIDTH{1'b0}};
         out_q  <= {WIDTH{1'b0}};
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         out_q  <= out_d;
         done_q <= done_d;
         err_q  <= err_d;
      end
   end

   assign bus.dout = out_q;
   assign bus.done = done_q;
endmodule

// File: tb/tb_xy_seq_multiplier.sv
// Scoreboard bench: a cycle-level reference model queues expected read data,
// an independent monitor compares whenever a read completes.
module tb_xy_seq_multiplier;
   localparam int W = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   xy_seq_multiplier_if #(.WIDTH(16)) bus ();
   xy_seq_multiplier_if #(.WIDTH(8))  bu8 ();
   xy_seq_multiplier_if #(.WIDTH(8))  bs8 ();

   xy_seq_multiplier #(.WIDTH(16), .SIGNED_EN(1'b1)) dut   (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
   xy_seq_multiplier #(.WIDTH(8),  .SIGNED_EN(1'b0)) dut_u8 (.clk_i(clk), .rst_ni(rst_n), .bus(bu8));
   xy_seq_multiplier #(.WIDTH(8),  .SIGNED_EN(1'b1)) dut_s8 (.clk_i(clk), .rst_ni(rst_n), .bus(bs8));

   assign bu8.e = bus.e;  assign bu8.w = bus.w;  assign bu8.r = bus.r;
   assign bu8.addr = bus.addr;  assign bu8.d = bus.d[7:0];
   assign bs8.e = bus.e;  assign bs8.w = bus.w;  assign bs8.r = bus.r;
   assign bs8.addr = bus.addr;  assign bs8.d = bus.d[7:0];

   int n_chk = 0;
   int n_err = 0;

   // reference model state (16-bit instance)
   logic [15:0] m_x, m_y, m_out;
   logic [31:0] m_prod, m_pend;
   logic        m_done, m_err;
   int          edge_n = 0;
   int          st_e   = 0;
   int          fin_e  = 0;
   logic [15:0] exp_q[$];
   logic        rd_seen = 1'b0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] ref_mul(logic [15:0] a, logic [15:0] b, logic sg);
      longint sa, sb, p;
      sa = longint'(a);
      sb = longint'(b);
      if (sg && a[15]) sa = sa - 65536;
      else             sa = sa;
      if (sg && b[15]) sb = sb - 65536;
      else             sb = sb;
      p = sa * sb;
      return p[31:0];
   endfunction

   // One bus cycle: drive, advance the model by one edge, then check DONE and OUT hold
   task automatic cyc(input logic rn, input logic e, input logic w, input logic r,
                      input logic [2:0] a, input logic [15:0] dd);
      logic        busy;
      logic [15:0] rv;
      @(negedge clk);
      rst_n = rn; bus.e = e; bus.w = w; bus.r = r; bus.addr = a; bus.d = dd;
      edge_n++;
      busy = (edge_n > st_e) && (edge_n <= fin_e);
      if (!rn) begin
         m_x = 16'h0; m_y = 16'h0; m_out = 16'h0; m_prod = 32'h0;
         m_done = 1'b0; m_err = 1'b0; st_e = 0; fin_e = 0;
      end else begin
         if (e && r) begin
            case (a)
               3'd0:    rv = m_x;
               3'd1:    rv = m_y;
               3'd2:    rv = m_prod[15:0];
               3'd3:    rv = m_prod[31:16];
               3'd4:    rv = {13'd0, m_err, m_done, busy};
               default: rv = 16'h0;
            endcase
            exp_q.push_back(rv);
            m_out = rv;
            if (a == 3'd4) begin m_done = 1'b0; m_err = 1'b0; end
         end
         if (e && w) begin
            if (busy && (a == 3'd0 || a == 3'd1 || a == 3'd4)) m_err = 1'b1;
            else if (a == 3'd0) m_x = dd;
            else if (a == 3'd1) m_y = dd;
            else if (a == 3'd4 && dd[0]) begin
               m_pend = ref_mul(m_x, m_y, dd[1]);
               m_done = 1'b0;
               st_e   = edge_n;
               fin_e  = edge_n + W + 1;
            end
         end
         if (edge_n == fin_e) begin m_prod = m_pend; m_done = 1'b1; end
      end
      @(posedge clk);
      #1;
      chk("done_pin", {31'd0, bus.done}, {31'd0, m_done});
      if (!(e && r) || !rn) chk("out_hold", {16'd0, bus.dout}, {16'd0, m_out});
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] dd); cyc(1'b1, 1'b1, 1'b1, 1'b0, a, dd); endtask
   task automatic rd(input logic [2:0] a); cyc(1'b1, 1'b1, 1'b0, 1'b1, a, 16'h0); endtask
   task automatic idle(input int n); repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0); endtask

   // 8-bit instances: SIGNED requested on both, only dut_s8 honours it
   task automatic t8(input logic [7:0] x, input logic [7:0] y,
                     input logic [15:0] exp_u, input logic [15:0] exp_s);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
      wr(3'd0, {8'h00, x});
      wr(3'd1, {8'h00, y});
      wr(3'd4, 16'h0003);
      idle(8);
      chk("u8_done_early", {31'd0, bu8.done}, 32'd0);
      idle(1);
      chk("u8_done_lat", {31'd0, bu8.done}, 32'd1);
      chk("s8_done_lat", {31'd0, bs8.done}, 32'd1);
      idle(9);
      rd(3'd2);
      chk("u8_plo", {24'd0, bu8.dout}, {24'd0, exp_u[7:0]});
      chk("s8_plo", {24'd0, bs8.dout}, {24'd0, exp_s[7:0]});
      rd(3'd3);
      chk("u8_phi", {24'd0, bu8.dout}, {24'd0, exp_u[15:8]});
      chk("s8_phi", {24'd0, bs8.dout}, {24'd0, exp_s[15:8]});
   endtask

   function automatic logic [15:0] rnd16();
      case ($urandom_range(0, 5))
         0:       return 16'h0000;
         1:       return 16'hFFFF;
         2:       return 16'h8000;
         3:       return 16'h7FFF;
         default: return 16'($urandom);
      endcase
   endfunction

   // Completed-read flag, one per edge where a read was accepted
   always @(posedge clk) rd_seen <= bus.e & bus.r & rst_n;

   // Monitor: pop and compare whenever the DUT presents read data
   always @(negedge clk) begin
      if (rd_seen) begin
         if (exp_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL rd_unexpected: got 0x%0h expected no read", bus.dout);
         end else begin
            chk("rd_data", {16'd0, bus.dout}, {16'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      bus.e = 1'b0; bus.w = 1'b0; bus.r = 1'b0; bus.addr = 3'd0; bus.d = 16'h0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 16'h0001);
      rd(3'd4); rd(3'd2); rd(3'd3);
      // unsigned max * max
      wr(3'd0, 16'hFFFF); wr(3'd1, 16'hFFFF); wr(3'd4, 16'h0001);
      idle(18); rd(3'd2); rd(3'd3); rd(3'd4);
      // signed -3 * 5 and MIN * MIN
      wr(3'd0, 16'hFFFD); wr(3'd1, 16'h0005); wr(3'd4, 16'h0003);
      idle(18); rd(3'd2); rd(3'd3);
      wr(3'd0, 16'h8000); wr(3'd1, 16'h8000); wr(3'd4, 16'h0003);
      idle(18); rd(3'd2); rd(3'd3);
      // writes while busy are rejected and flag ERR
      wr(3'd0, 16'h0011); wr(3'd1, 16'h0022); wr(3'd4, 16'h0001);
      idle(4); wr(3'd0, 16'h1234); wr(3'd4, 16'h0001);
      idle(15); rd(3'd2); rd(3'd4); rd(3'd4); rd(3'd0);
      // reset mid-run, then a fresh run
      wr(3'd4, 16'h0001); idle(6);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
      rd(3'd4); rd(3'd2); rd(3'd3); rd(3'd0); rd(3'd1);
      wr(3'd0, 16'h0007); wr(3'd1, 16'h0009); wr(3'd4, 16'h0001);
      idle(18); rd(3'd2); rd(3'd4);
      // bus enable gating and read-before-write on the same edge
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 16'h00AA);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 16'h00AA);
      rd(3'd0);
      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic       en;
         logic [2:0] a;
         en = ($urandom_range(0, 15) != 0);
         a  = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 11))
            0, 1:    cyc(1'b1, en, 1'b1, 1'b0, 3'd0, rnd16());
            2, 3:    cyc(1'b1, en, 1'b1, 1'b0, 3'd1, rnd16());
            4:       cyc(1'b1, en, 1'b1, 1'b0, 3'd4, {14'd0, 1'($urandom), ($urandom_range(0, 3) != 0)});
            5, 6, 7: cyc(1'b1, en, 1'b0, 1'b1, a, 16'h0);
            8:       cyc(1'b1, en, 1'b1, 1'($urandom), a, rnd16());
            9:       cyc(($urandom_range(0, 40) != 0), 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
            default: idle(1);
         endcase
      end
      idle(20); rd(3'd2); rd(3'd3); rd(3'd4);
      // narrow instances, unsigned-only versus signed-enabled
      t8(8'h80, 8'h80, 16'h4000, 16'h4000);
      t8(8'hFF, 8'h02, 16'h01FE, 16'hFFFE);
      idle(2);
      chk("drain", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
